// File: rtl/task_reg_bank_if.sv
// Request channel of task_reg_bank: a valid/ready handshake that carries
// the operation, the target channel and the operand.
interface task_reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int CHW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [CHW-1:0]   req_ch;
  logic [WIDTH-1:0] req_data;

  modport master (output req_valid, req_op, req_ch, req_data, input req_ready);
  modport slave  (input req_valid, req_op, req_ch, req_data, output req_ready);
endinterface

// File: rtl/task_reg_bank.sv
// task_reg_bank: NUM_CH x WIDTH register bank driven by a request handshake
// (WRITE / ACCUM / CLEAR_ONE / CLEAR_ALL) with a registered read-back port.
// CLEAR_ALL runs a one-channel-per-cycle sweep while requests are held off.
// Optional feature macro: TASK_REG_BANK_PARITY_EN adds a per-channel even
// parity bit, an inj_perr fault-injection input and an rd_perr output.
module task_reg_bank #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CHW    = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  task_reg_bank_if.slave    req,
  input  logic [CHW-1:0]    rd_ch,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              ovf,
  output logic              err_oob
`ifdef TASK_REG_BANK_PARITY_EN
  ,
  input  logic              inj_perr,
  output logic              rd_perr
`endif
);

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_ACCUM   = 2'b01;
  localparam logic [1:0] OP_CLR_ONE = 2'b10;
  localparam logic [1:0] OP_CLR_ALL = 2'b11;

  localparam logic [CHW:0]   NUM_CH_W = (CHW+1)'(NUM_CH);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e           state_q;
  logic             busy_q;
  logic [CHW-1:0]   idx_q;
  logic [WIDTH-1:0] regs_q [NUM_CH];
  logic [WIDTH-1:0] rd_data_q;
  logic             ovf_q;
  logic             err_oob_q;
`ifdef TASK_REG_BANK_PARITY_EN
  logic             par_q [NUM_CH];
  logic             rd_perr_q;
`endif

  logic             accept;
  logic             ch_ok;
  logic             rd_ok;
  logic [CHW-1:0]   ch_idx;
  logic [CHW-1:0]   rd_idx;
  logic [WIDTH:0]   acc_sum_d;

  // Ready is dropped during reset as well as during the sweep.
  assign req.req_ready = (state_q == IDLE) && !rst;
  assign accept        = req.req_valid && req.req_ready;

  // Out-of-range indices are steered to channel 0 so array reads stay in
  // bounds; the *_ok flags gate any effect they could have.
  assign ch_ok  = ({1'b0, req.req_ch} < NUM_CH_W);
  assign rd_ok  = ({1'b0, rd_ch} < NUM_CH_W);
  assign ch_idx = ch_ok ? req.req_ch : '0;
  assign rd_idx = rd_ok ? rd_ch : '0;

  // One extra bit keeps the carry out of the MSB for the overflow flag.
  assign acc_sum_d = {1'b0, regs_q[ch_idx]} + {1'b0, req.req_data};

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign err_oob = err_oob_q;
`ifdef TASK_REG_BANK_PARITY_EN
  assign rd_perr = rd_perr_q;
`endif

  task automatic do_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      regs_q[i] <= '0;
`ifdef TASK_REG_BANK_PARITY_EN
      par_q[i]  <= 1'b0;
`endif
    end
    state_q   <= IDLE;
    busy_q    <= 1'b0;
    idx_q     <= '0;
    rd_data_q <= '0;
    ovf_q     <= 1'b0;
    err_oob_q <= 1'b0;
`ifdef TASK_REG_BANK_PARITY_EN
    rd_perr_q <= 1'b0;
`endif
  endtask

  task automatic do_write(input logic [CHW-1:0] ch, input logic [WIDTH-1:0] d);
    regs_q[ch] <= d;
`ifdef TASK_REG_BANK_PARITY_EN
    // Injection flips the stored parity so the read side reports a mismatch.
    par_q[ch]  <= (^d) ^ inj_perr;
`endif
  endtask

  task automatic do_accum(input logic [CHW-1:0] ch);
    regs_q[ch] <= acc_sum_d[WIDTH-1:0];
    ovf_q      <= ovf_q | acc_sum_d[WIDTH];
`ifdef TASK_REG_BANK_PARITY_EN
    par_q[ch]  <= ^acc_sum_d[WIDTH-1:0];
`endif
  endtask

  task automatic do_clear_one(input logic [CHW-1:0] ch);
    regs_q[ch] <= '0;
`ifdef TASK_REG_BANK_PARITY_EN
    par_q[ch]  <= 1'b0;
`endif
  endtask

  task automatic do_start_sweep();
    state_q <= SWEEP;
    busy_q  <= 1'b1;
    idx_q   <= '0;
  endtask

  // Clears one channel per cycle; the last clear also returns to IDLE so
  // the whole sweep takes exactly NUM_CH cycles.
  task automatic do_sweep_step();
    do_clear_one(idx_q);
    if (idx_q == LAST_CH) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      idx_q   <= idx_q + 1'b1;
    end
  endtask

  // Bank state, FSM, flags and the read-before-write read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_reset();
    end else begin
      err_oob_q <= 1'b0;
      rd_data_q <= rd_ok ? regs_q[rd_idx] : '0;
`ifdef TASK_REG_BANK_PARITY_EN
      rd_perr_q <= rd_ok ? (par_q[rd_idx] != (^regs_q[rd_idx])) : 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req.req_op == OP_CLR_ALL) begin
              do_start_sweep();
            end else if (!ch_ok) begin
              err_oob_q <= 1'b1;
            end else begin
              case (req.req_op)
                OP_WRITE:   do_write(ch_idx, req.req_data);
                OP_ACCUM:   do_accum(ch_idx);
                OP_CLR_ONE: do_clear_one(ch_idx);
                default:    ;
              endcase
            end
          end
        end
        SWEEP:   do_sweep_step();
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_reg_bank.sv
// Bench for task_reg_bank: a NUM_CH=4 instance driven from a vector table
// with a read-back scoreboard, and a NUM_CH=5 instance for out-of-range
// channel and reset-during-sweep sequences.
module tb_task_reg_bank;

  localparam logic [1:0] WR = 2'b00, AC = 2'b01, CO = 2'b10, CA = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] rd_ch_a;
  logic [2:0] rd_ch_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       busy_a, busy_b, ovf_a, ovf_b, err_a, err_b;
`ifdef TASK_REG_BANK_PARITY_EN
  logic       inj_a, inj_b, perr_a, perr_b;
`endif

  task_reg_bank_if #(.WIDTH(8), .NUM_CH(4)) ifa ();
  task_reg_bank_if #(.WIDTH(8), .NUM_CH(5)) ifb ();

  task_reg_bank #(.WIDTH(8), .NUM_CH(4)) dut_a (
    .clk(clk), .rst(rst_a), .req(ifa), .rd_ch(rd_ch_a), .rd_data(rd_data_a),
    .busy(busy_a), .ovf(ovf_a), .err_oob(err_a)
`ifdef TASK_REG_BANK_PARITY_EN
    , .inj_perr(inj_a), .rd_perr(perr_a)
`endif
  );

  task_reg_bank #(.WIDTH(8), .NUM_CH(5)) dut_b (
    .clk(clk), .rst(rst_b), .req(ifb), .rd_ch(rd_ch_b), .rd_data(rd_data_b),
    .busy(busy_b), .ovf(ovf_b), .err_oob(err_b)
`ifdef TASK_REG_BANK_PARITY_EN
    , .inj_perr(inj_b), .rd_perr(perr_b)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] op;
    logic [1:0] ch;
    logic [7:0] data;
    logic [1:0] rch;
    logic       rdy;   // req_ready before the edge
    logic [7:0] rd;    // rd_data after the edge
    logic       ovf;   // after the edge
    logic       busy;  // after the edge
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] rd;
    logic       ovf;
    logic       busy;
  } exp_t;

  localparam int NV = 26;
  vec_t vt [NV];
  exp_t sbq [$];

  function automatic vec_t mk(logic v, logic [1:0] op, logic [1:0] ch, logic [7:0] d,
                              logic [1:0] rch, logic rdy, logic [7:0] rd, logic o, logic b);
    vec_t r;
    r.vld = v; r.op = op; r.ch = ch; r.data = d; r.rch = rch;
    r.rdy = rdy; r.rd = rd; r.ovf = o; r.busy = b;
    return r;
  endfunction

  task automatic a_cycle(input logic v, input logic [1:0] op, input logic [1:0] ch,
                         input logic [7:0] d, input logic [1:0] rch);
    @(negedge clk);
    ifa.req_valid = v; ifa.req_op = op; ifa.req_ch = ch; ifa.req_data = d; rd_ch_a = rch;
    @(posedge clk); #1;
  endtask

  task automatic b_cycle(input logic v, input logic [1:0] op, input logic [2:0] ch,
                         input logic [7:0] d, input logic [2:0] rch);
    @(negedge clk);
    ifb.req_valid = v; ifb.req_op = op; ifb.req_ch = ch; ifb.req_data = d; rd_ch_b = rch;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Reset/readback, write, accumulate with wrap, preload, CLEAR_ALL with a
    // write held across the sweep, CLEAR_ONE.
    vt[0]  = mk(0, WR, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    vt[1]  = mk(0, WR, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    vt[2]  = mk(0, WR, 0, 8'h00, 2, 1, 8'h00, 0, 0);
    vt[3]  = mk(0, WR, 0, 8'h00, 3, 1, 8'h00, 0, 0);
    vt[4]  = mk(1, WR, 2, 8'hA5, 2, 1, 8'h00, 0, 0);
    vt[5]  = mk(0, WR, 0, 8'h00, 2, 1, 8'hA5, 0, 0);
    vt[6]  = mk(1, WR, 1, 8'hF0, 1, 1, 8'h00, 0, 0);
    vt[7]  = mk(1, AC, 1, 8'h20, 1, 1, 8'hF0, 1, 0);
    vt[8]  = mk(1, AC, 1, 8'h01, 1, 1, 8'h10, 1, 0);
    vt[9]  = mk(0, WR, 0, 8'h00, 1, 1, 8'h11, 1, 0);
    vt[10] = mk(1, WR, 0, 8'h11, 0, 1, 8'h00, 1, 0);
    vt[11] = mk(1, WR, 1, 8'h22, 1, 1, 8'h11, 1, 0);
    vt[12] = mk(1, WR, 2, 8'h33, 2, 1, 8'hA5, 1, 0);
    vt[13] = mk(1, WR, 3, 8'h44, 3, 1, 8'h00, 1, 0);
    vt[14] = mk(1, CA, 0, 8'h00, 0, 1, 8'h11, 1, 1);
    vt[15] = mk(1, WR, 1, 8'h5A, 0, 0, 8'h11, 1, 1);
    vt[16] = mk(1, WR, 1, 8'h5A, 1, 0, 8'h22, 1, 1);
    vt[17] = mk(1, WR, 1, 8'h5A, 0, 0, 8'h00, 1, 1);
    vt[18] = mk(1, WR, 1, 8'h5A, 3, 0, 8'h44, 1, 0);
    vt[19] = mk(1, WR, 1, 8'h5A, 1, 1, 8'h00, 1, 0);
    vt[20] = mk(0, WR, 0, 8'h00, 1, 1, 8'h5A, 1, 0);
    vt[21] = mk(0, WR, 0, 8'h00, 0, 1, 8'h00, 1, 0);
    vt[22] = mk(0, WR, 0, 8'h00, 2, 1, 8'h00, 1, 0);
    vt[23] = mk(0, WR, 0, 8'h00, 3, 1, 8'h00, 1, 0);
    vt[24] = mk(1, CO, 1, 8'h00, 1, 1, 8'h5A, 1, 0);
    vt[25] = mk(0, WR, 0, 8'h00, 1, 1, 8'h00, 1, 0);

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_op = WR; ifa.req_ch = '0; ifa.req_data = '0; rd_ch_a = '0;
    ifb.req_valid = 1'b0; ifb.req_op = WR; ifb.req_ch = '0; ifb.req_data = '0; rd_ch_b = '0;
`ifdef TASK_REG_BANK_PARITY_EN
    inj_a = 1'b0; inj_b = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready low", 32'(ifa.req_ready), 32'd0);
    chk("rst rd_data",   32'(rd_data_a), 32'd0);
    chk("rst ovf",       32'(ovf_a), 32'd0);
    chk("rst busy",      32'(busy_a), 32'd0);
    chk("rst err_oob",   32'(err_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("ready after rst", 32'(ifa.req_ready), 32'd1);

    // Table-driven run on the 4-channel bank with a read-back scoreboard.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ifa.req_valid = vt[i].vld; ifa.req_op = vt[i].op; ifa.req_ch = vt[i].ch;
      ifa.req_data = vt[i].data; rd_ch_a = vt[i].rch;
      #1;
      chk($sformatf("v%0d ready", i), 32'(ifa.req_ready), 32'(vt[i].rdy));
      e.idx = i; e.rd = vt[i].rd; e.ovf = vt[i].ovf; e.busy = vt[i].busy;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d rd_data", e.idx), 32'(rd_data_a), 32'(e.rd));
        chk($sformatf("v%0d ovf", e.idx),     32'(ovf_a), 32'(e.ovf));
        chk($sformatf("v%0d busy", e.idx),    32'(busy_a), 32'(e.busy));
        chk($sformatf("v%0d err_oob", e.idx), 32'(err_a), 32'd0);
      end
    end
    ifa.req_valid = 1'b0;

`ifdef TASK_REG_BANK_PARITY_EN
    // Parity fault injection and repair on channel 0.
    inj_a = 1'b1;
    a_cycle(1, WR, 0, 8'h07, 0);
    inj_a = 1'b0;
    a_cycle(0, WR, 0, 8'h00, 0);
    chk("par inj rd_data", 32'(rd_data_a), 32'h07);
    chk("par inj rd_perr", 32'(perr_a), 32'd1);
    a_cycle(1, WR, 0, 8'h07, 0);
    a_cycle(0, WR, 0, 8'h00, 0);
    chk("par clean rd_perr", 32'(perr_a), 32'd0);
`endif

    // 5-channel bank: last in-range channel, then an out-of-range write.
    b_cycle(1, WR, 3'd4, 8'h3C, 3'd0);
    chk("b ch4 err_oob", 32'(err_b), 32'd0);
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_op = WR; ifb.req_ch = 3'd6; ifb.req_data = 8'h77; rd_ch_b = 3'd0;
    #1;
    chk("b oob ready", 32'(ifb.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b oob pulse", 32'(err_b), 32'd1);
    b_cycle(0, WR, 3'd0, 8'h00, 3'd6);
    chk("b oob pulse end", 32'(err_b), 32'd0);
    chk("b rd ch6", 32'(rd_data_b), 32'd0);
    for (int c = 0; c < 6; c++) begin
      b_cycle(0, WR, 3'd0, 8'h00, 3'(c));
      chk($sformatf("b after oob ch%0d", c), 32'(rd_data_b), (c == 4) ? 32'h3C : 32'h0);
    end

    // Reset in the second sweep cycle aborts the sweep and zeroes the bank.
    b_cycle(1, WR, 3'd0, 8'h12, 3'd0);
    b_cycle(1, WR, 3'd3, 8'h34, 3'd0);
    b_cycle(1, CA, 3'd0, 8'h00, 3'd0);
    chk("b sweep busy", 32'(busy_b), 32'd1);
    b_cycle(0, WR, 3'd0, 8'h00, 3'd3);
    chk("b sweep1 busy", 32'(busy_b), 32'd1);
    chk("b sweep1 rd ch3", 32'(rd_data_b), 32'h34);
    rst_b = 1'b1;
    b_cycle(0, WR, 3'd0, 8'h00, 3'd0);
    chk("b midrst busy", 32'(busy_b), 32'd0);
    chk("b midrst ready", 32'(ifb.req_ready), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b post rst ready", 32'(ifb.req_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      b_cycle(0, WR, 3'd0, 8'h00, 3'(c));
      chk($sformatf("b post rst ch%0d", c), 32'(rd_data_b), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/task_reg_bank.md
Name: task_reg_bank

Overview:
- Parametrised multi-channel register bank, the next generation of the single-register task-driven write block.
- Accepts operation requests over a valid/ready handshake: write, accumulate, clear-one, clear-all.
- Provides a registered read-back port.
- Sits as a generic state/config store in front-end test designs; also serves as a synthesis regression case for task-based sequential logic.

Parameters:
- WIDTH, 8, data width of each channel register
- NUM_CH, 4, number of channels (2..64, need not be a power of two)
- CHW, max($clog2(NUM_CH),1), channel index width (derived, localparam)

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  bank can accept a request this cycle
- req_op  input  2  00 WRITE, 01 ACCUM, 10 CLEAR_ONE, 11 CLEAR_ALL
- req_ch  input  CHW  target channel (ignored for CLEAR_ALL)
- req_data  input  WIDTH  operand for WRITE/ACCUM
- rd_ch  input  CHW  read channel select
- rd_data  output  WIDTH  registered read data
- busy  output  1  high while CLEAR_ALL sweep in progress
- ovf  output  1  sticky accumulate-overflow flag
- err_oob  output  1  one-cycle pulse: accepted request with req_ch >= NUM_CH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all channel registers 0, rd_data 0, ovf 0, err_oob 0, busy 0, FSM in IDLE, sweep index 0.
- Reset mid-sweep aborts the sweep. Remaining channels are zeroed by reset itself.
- Handshake:
  - A request is accepted when req_valid && req_ready at a rising edge.
  - req_ready = (state == IDLE) && !rst.
  - The register update is visible in the bank one cycle after acceptance.
- Operations (on accepted request, req_ch < NUM_CH):
  - WRITE: reg[ch] <= req_data.
  - ACCUM: reg[ch] <= reg[ch] + req_data, modulo 2^WIDTH (wraps). ovf is set if the carry out of bit WIDTH-1 is 1. ovf clears only on rst.
  - CLEAR_ONE: reg[ch] <= 0.
  - CLEAR_ALL: enter SWEEP. req_ch and req_data are ignored.
- Out-of-range channel (req_ch >= NUM_CH, non-CLEAR_ALL): no register changes. err_oob pulses high for exactly the cycle after acceptance.
- FSM:
  - IDLE -> SWEEP on accepted CLEAR_ALL. Sweep index is set to 0.
  - SWEEP: each cycle, reg[idx] <= 0 and idx increments. busy = 1, req_ready = 0.
  - When idx == NUM_CH-1, that register is cleared and the FSM returns to IDLE.
  - Sweep occupies exactly NUM_CH cycles. req_ready rises on the cycle after the last clear.
- Requests asserted during SWEEP are held off, not dropped. The requester keeps req_valid high until req_ready.
- Read port:
  - rd_data <= reg[rd_ch] every cycle; 1-cycle latency.
  - Read-before-write: reading the channel being updated in the same cycle returns the old value.
  - rd_ch >= NUM_CH returns 0.
  - Reads remain functional during SWEEP and return current (partly cleared) contents.
- Register updates are implemented through tasks: one task per op, plus an automatic reset task called from the rst branch.

Optional Feature:
- Macro: TASK_REG_BANK_PARITY_EN.
- Defined:
  - Each channel stores an extra even-parity bit, computed on every write, accumulate, or clear (parity of 0 is 0).
  - Adds output rd_perr (1 bit), registered alongside rd_data, high when the stored parity mismatches the stored data of rd_ch.
  - Adds input inj_perr (1 bit): when high on an accepted WRITE, the stored parity bit is inverted for fault-injection testing.
  - rd_perr resets to 0.
- Undefined: no parity storage; rd_perr and inj_perr ports absent.

Test Plan:
- Reset then read all channels: rst high 2 cycles, rd_ch 0..3 -> rd_data 0 each, ovf 0, req_ready 1 after rst low.
- WRITE ch2 = 0xA5, next cycle rd_ch=2 -> rd_data 0xA5 one cycle later. Same-cycle read of ch2 during the write -> old value 0x00.
- ACCUM ch1: WRITE 0xF0, then ACCUM 0x20 -> reg 0x10 (wrapped), ovf 1. Then ACCUM 0x01 -> 0x11, ovf stays 1.
- CLEAR_ALL with channels preloaded 0x11/0x22/0x33/0x44 (NUM_CH=4):
  - busy high exactly 4 cycles; req_ready low during sweep.
  - A WRITE held valid during the sweep is accepted on the first ready cycle.
  - After the sweep, all channels read 0 except the pending write's target.
- NUM_CH=5, WRITE to ch 6 (CHW=3) -> err_oob single-cycle pulse, no register changes, rd_ch=6 reads 0. Also: rst asserted mid-sweep at cycle 2 -> busy 0 next cycle, all channels 0.
- With TASK_REG_BANK_PARITY_EN:
  - WRITE ch0=0x07 with inj_perr=1 -> rd_perr 1 on ch0.
  - Rewrite ch0=0x07 with inj_perr=0 -> rd_perr 0.
